hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use / HI-LO / mult-div structural stalls, branch flush, and the mult/div busy tracker.
// Stage enables and flushes are combinational; Md_Busy/Md_Done are registered. Define HAZARD_STALL_CNT_EN to add the 32-bit Stall_Cnt output.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_Rt,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IDEX_MdOp,
    input  logic       IDEX_MdDiv,
    input  logic       IFID_MdOp,
    input  logic       IFID_UsesHiLo,
    input  logic       Branch_Taken,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       Md_Busy,
    output logic       Md_Done
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] Stall_Cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    // The counter holds remaining busy cycles minus one, so 0 marks the last busy cycle.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       load_use;
    logic       hilo_haz;
    logic       md_struct;
    logic       stall;

    always_comb begin
        load_use  = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
        hilo_haz  = IFID_UsesHiLo && (busy_q || IDEX_MdOp);
        md_struct = IFID_MdOp && (busy_q || IDEX_MdOp);
        stall     = load_use || hilo_haz || md_struct;
    end

    // A taken branch squashes both younger instructions, so any stall is moot.
    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        if (Branch_Taken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (stall) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (IDEX_MdOp) begin
                    if (IDEX_MdDiv) begin
                        state_d = DIV;
                        cnt_d   = DIV_LOAD;
                    end else begin
                        state_d = MUL;
                        cnt_d   = MUL_LOAD;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt_q == 6'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Md_Busy = busy_q;
    assign Md_Done = done_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 32'd0;
        end else if (!PC_Write) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with default parameters (MUL_CYCLES=4, DIV_CYCLES=32).
module tb_hazard_ctrl;

    logic       clk;
    logic       rstn;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_Rt;
    logic [4:0] IFID_Rs;
    logic [4:0] IFID_Rt;
    logic       IDEX_MdOp;
    logic       IDEX_MdDiv;
    logic       IFID_MdOp;
    logic       IFID_UsesHiLo;
    logic       Branch_Taken;
    logic       PC_Write;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Flush;
    logic       Md_Busy;
    logic       Md_Done;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] Stall_Cnt;
`endif

    int checks;
    int failures;

    hazard_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_Rt      (IDEX_Rt),
        .IFID_Rs      (IFID_Rs),
        .IFID_Rt      (IFID_Rt),
        .IDEX_MdOp    (IDEX_MdOp),
        .IDEX_MdDiv   (IDEX_MdDiv),
        .IFID_MdOp    (IFID_MdOp),
        .IFID_UsesHiLo(IFID_UsesHiLo),
        .Branch_Taken (Branch_Taken),
        .PC_Write     (PC_Write),
        .IFID_Write   (IFID_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Flush   (IDEX_Flush),
        .Md_Busy      (Md_Busy),
        .Md_Done      (Md_Done)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .Stall_Cnt    (Stall_Cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush} for compact comparisons.
    function automatic logic [3:0] ctl();
        return {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush};
    endfunction

    task automatic clear_inputs();
        IDEX_MemRead  = 1'b0;
        IDEX_Rt       = 5'd0;
        IFID_Rs       = 5'd0;
        IFID_Rt       = 5'd0;
        IDEX_MdOp     = 1'b0;
        IDEX_MdDiv    = 1'b0;
        IFID_MdOp     = 1'b0;
        IFID_UsesHiLo = 1'b0;
        Branch_Taken  = 1'b0;
    endtask

    initial begin
        int n;
        int done_seen;
        int busy_seen;
        checks   = 0;
        failures = 0;
        clear_inputs();
        rstn = 1'b0;

        // Reset state
        #2;
        check("rst_busy", Md_Busy, 1'b0);
        check("rst_done", Md_Done, 1'b0);
        check("rst_ctl", ctl(), 4'b1100);
`ifdef HAZARD_STALL_CNT_EN
        check("rst_stallcnt", Stall_Cnt, 32'd0);
`endif
        // Combinational outputs follow inputs while in reset
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rt = 5'd9;
        #1;
        check("rst_loaduse_ctl", ctl(), 4'b0001);
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Load-use table: {MemRead, IDEX_Rt, IFID_Rs, IFID_Rt} -> ctl
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; IFID_Rt = 5'd1;
        #1; check("lu_rs_match", ctl(), 4'b0001);
        IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
        #1; check("lu_rt_zero", ctl(), 4'b1100);
        IDEX_Rt = 5'd7; IFID_Rs = 5'd3; IFID_Rt = 5'd7;
        #1; check("lu_rt_match", ctl(), 4'b0001);
        IFID_Rt = 5'd4;
        #1; check("lu_no_match", ctl(), 4'b1100);
        IDEX_MemRead = 1'b0; IFID_Rt = 5'd7;
        #1; check("lu_not_load", ctl(), 4'b1100);
        IDEX_MemRead = 1'b1; Branch_Taken = 1'b1;
        #1; check("lu_branch", ctl(), 4'b1111);
        Branch_Taken = 1'b0; IFID_MdOp = 1'b1;
        #1; check("lu_idle_mdop_nostall", ctl(), 4'b0001);
        clear_inputs();
        #1; check("idle_no_md_haz", ctl(), 4'b1100);
        tick();

        // Multiply: acceptance cycle, IFID mult/div conflicts with the EX one
        IDEX_MdOp = 1'b1; IDEX_MdDiv = 1'b0; IFID_MdOp = 1'b1;
        #1;
        check("mul_acc_struct", ctl(), 4'b0001);
        check("mul_acc_busy", Md_Busy, 1'b0);
        tick();
        IDEX_MdOp = 1'b0; IFID_MdOp = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            IDEX_MdOp = (i == 2);
            IFID_MdOp = (i == 3);
            #1;
            check($sformatf("mul_busy_c%0d", i), Md_Busy, 1'b1);
            check($sformatf("mul_done_c%0d", i), Md_Done, 1'b0);
            if (i == 3) check("mul_busy_struct", ctl(), 4'b0001);
            tick();
            IDEX_MdOp = 1'b0; IFID_MdOp = 1'b0;
        end
        #1;
        check("mul_c5_busy", Md_Busy, 1'b0);
        check("mul_c5_done", Md_Done, 1'b1);
        // Back-to-back: accept a new multiply in the Md_Done cycle
        IDEX_MdOp = 1'b1; IDEX_MdDiv = 1'b0;
        tick();
        IDEX_MdOp = 1'b0;
        #1;
        check("b2b_c1_busy", Md_Busy, 1'b1);
        check("b2b_c1_done", Md_Done, 1'b0);
        tick(); tick(); tick();
        check("b2b_c4_busy", Md_Busy, 1'b1);
        tick();
        check("b2b_c5_busy", Md_Busy, 1'b0);
        check("b2b_c5_done", Md_Done, 1'b1);
        tick();
        check("b2b_c6_done", Md_Done, 1'b0);

        // Divide with a HI/LO reader held in ID: 33 stalled cycles
        IDEX_MdOp = 1'b1; IDEX_MdDiv = 1'b1; IFID_UsesHiLo = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (PC_Write) break;
            n++;
            tick();
            IDEX_MdOp = 1'b0;
        end
        check("div_hilo_stall_cycles", n, 33);
        check("div_release_done", Md_Done, 1'b1);
        check("div_release_ctl", ctl(), 4'b1100);
        clear_inputs();
        tick();

        // Divide aborted by reset when cnt==10 (22nd cycle after acceptance)
        IDEX_MdOp = 1'b1; IDEX_MdDiv = 1'b1;
        tick();
        IDEX_MdOp = 1'b0;
        for (int c = 1; c < 22; c++) begin
            if (c == 5) begin
                Branch_Taken = 1'b1;
                #1;
                check("div_branch_ctl", ctl(), 4'b1111);
                check("div_branch_busy", Md_Busy, 1'b1);
                Branch_Taken = 1'b0;
            end
            tick();
        end
        check("div_c22_busy", Md_Busy, 1'b1);
        rstn = 1'b0;
        #1;
        check("abort_busy", Md_Busy, 1'b0);
        check("abort_done", Md_Done, 1'b0);
`ifdef HAZARD_STALL_CNT_EN
        check("abort_stallcnt", Stall_Cnt, 32'd0);
`endif
        tick();
        rstn = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (Md_Done) done_seen++;
            if (Md_Busy) busy_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_no_busy", busy_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
